shift_right_seq: RTL

Iterative right-shift unit for the MIPS pipeline's EX stage, executing SRL and SRA one bit position per clock. It complements the combinational shift-left-by-two used for branch-offset generation. The pipeline stalls on `busy` while a shift is in flight, so the block needs no barrel-shifter area. Operands are captured on `start`, and the result is presented with a one-cycle `done` pulse.

---
 rtl/shift_right_seq_pkg.sv | 21 ++
 rtl/shift_right_step.sv | 12 +
 rtl/shift_right_seq.sv | 81 ++++++++
 3 files changed

// File: rtl/shift_right_seq_pkg.sv
// shift_right_seq_pkg: state and shift-op encodings shared by the EX-stage shifter
// and the ALU control decode.
package shift_right_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_DONE  = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10
    } shift_op_e;

    function automatic shift_op_e right_op(input logic arith);
        return arith ? OP_SRA : OP_SRL;
    endfunction

endpackage

// File: rtl/shift_right_step.sv
// shift_right_step: single-position right shift with an explicit fill bit.
module shift_right_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] in_data,
    input  logic             fill,
    output logic [WIDTH-1:0] out_data
);

    assign out_data = {fill, in_data[WIDTH-1:1]};

endmodule

// File: rtl/shift_right_seq.sv
// shift_right_seq: iterative SRL/SRA, one bit position per clock, with busy stall
// and a one-cycle done pulse.
module shift_right_seq
    import shift_right_seq_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               arith,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] shamt,
    output logic [WIDTH-1:0]   out_data,
    output logic               busy,
    output logic               done
);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic               fill_q, fill_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic [WIDTH-1:0]   step_data;

    shift_right_step #(.WIDTH(WIDTH)) u_step (
        .in_data  (work_q),
        .fill     (fill_q),
        .out_data (step_data)
    );

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        fill_d  = fill_q;
        out_d   = out_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = start ? S_SHIFT : S_IDLE;
                if (start) begin
                    work_d = in_data;
                    cnt_d  = shamt;
                    fill_d = arith & in_data[WIDTH-1];
                end
            end
            S_SHIFT: begin
                if (cnt_q != '0) begin
                    work_d = step_data;
                    cnt_d  = cnt_q - SHAMT_W'(1);
                end else begin
                    out_d   = work_q;
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            work_q  <= '0;
            cnt_q   <= '0;
            fill_q  <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            fill_q  <= fill_d;
            out_q   <= out_d;
        end
    end

    assign out_data = out_q;
    assign busy     = (state_q == S_SHIFT);
    assign done     = (state_q == S_DONE);

endmodule
